// File: rtl/uart_start_ctrl.sv
// uart_start_ctrl: UART command receiver in front of the HLS start/finish
// controller. It deserialises bytes from uart_rx and turns a start command into
// the level uart_start. That level stays high until the core reports
// hls_finish or an abort byte arrives, so each accepted command gives exactly
// one rising edge. It also reports framing errors and start commands that
// arrive while a run is already pending.
//
// Build option: define UART_PARITY_EN for 8E1 framing. This adds a PARITY
// state between DATA and STOP, and a bad parity bit is reported through
// frame_err. With the macro undefined the frame is plain 8N1 and there is
// no parity state.
module uart_start_ctrl #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [7:0]  CMD_START = 8'h53,
    parameter logic [7:0]  CMD_ABORT = 8'h41
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       hls_finish,
    output logic       uart_start,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_drop
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_start_ctrl: CLK_FREQ/BAUD must be at least 4");
    end

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef UART_PARITY_EN
    logic             par_err;
`endif

    // Two-flop synchroniser for the asynchronous line; both flops idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with mid-bit sampling, plus command decode of each accepted byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            cmd_drop   <= 1'b0;
            uart_start <= 1'b0;
`ifdef UART_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            cmd_drop  <= 1'b0;

            // Decode acts on the byte presented with rx_valid. hls_finish wins
            // over any command in the same cycle.
            if (hls_finish) begin
                uart_start <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == CMD_ABORT) begin
                    uart_start <= 1'b0;
                end else if (rx_byte == CMD_START) begin
                    if (uart_start) begin
                        cmd_drop <= 1'b1;
                    end else begin
                        uart_start <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF_BIT;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end else if (!rx_s) begin
                        baud_cnt <= FULL_BIT;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end else begin
                        shift    <= {rx_s, shift[7:1]};
                        baud_cnt <= FULL_BIT;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end else begin
                        par_err  <= (^shift) ^ rx_s;
                        baud_cnt <= FULL_BIT;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end else begin
`ifdef UART_PARITY_EN
                        if (rx_s && !par_err) begin
`else
                        if (rx_s) begin
`endif
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_start_ctrl.sv
// Directed bench for uart_start_ctrl at 10 clocks per bit. Inputs are driven
// and outputs sampled on the falling clock edge. A monitor counts output pulses
// and records when rx_valid and uart_start rise.
module tb_uart_start_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic       hls_finish;
    logic       uart_start;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       cmd_drop;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_drop = 0;
    int n_rise = 0;
    int valid_cyc = 0;
    int rise_cyc = 0;
    logic prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_start_ctrl #(
        .CLK_FREQ (1152000),
        .BAUD     (115200),
        .CMD_START(8'h53),
        .CMD_ABORT(8'h41)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .hls_finish(hls_finish),
        .uart_start(uart_start),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .cmd_drop  (cmd_drop)
    );

    // Count pulses and record when rx_valid and uart_start rise.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_valid === 1'b1) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (cmd_drop === 1'b1) n_drop = n_drop + 1;
        if (uart_start === 1'b1 && prev_start === 1'b0) begin
            n_rise   = n_rise + 1;
            rise_cyc = cyc;
        end
        prev_start = uart_start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        idle(10);
    endtask

    // One frame. The stop bit level is selectable, and 5 idle clocks follow.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop);
        uart_rx = 1'b1;
        idle(5);
    endtask

    initial begin
        logic [7:0] partial;
        reset      = 1'b1;
        uart_rx    = 1'b1;
        hls_finish = 1'b0;
        idle(3);
        chk("reset_uart_start", 32'(uart_start), 32'd0);
        chk("reset_rx_byte",    32'(rx_byte),    32'h00);
        chk("reset_rx_valid",   32'(rx_valid),   32'd0);
        chk("reset_frame_err",  32'(frame_err),  32'd0);
        chk("reset_cmd_drop",   32'(cmd_drop),   32'd0);
        reset = 1'b0;
        idle(5);

        // A plain data byte is received but is not a command.
        send_byte(8'hA5, 1'b1);
        chk("a5_valid_cnt", 32'(n_valid),    32'd1);
        chk("a5_byte",      32'(rx_byte),    32'hA5);
        chk("a5_ferr_cnt",  32'(n_ferr),     32'd0);
        chk("a5_start",     32'(uart_start), 32'd0);

        // Start command: uart_start rises one cycle after rx_valid.
        send_byte(8'h53, 1'b1);
        chk("s1_valid_cnt", 32'(n_valid),             32'd2);
        chk("s1_start",     32'(uart_start),          32'd1);
        chk("s1_rise_cnt",  32'(n_rise),              32'd1);
        chk("s1_latency",   32'(rise_cyc - valid_cyc), 32'd1);

        // hls_finish 20 clocks later clears uart_start on the next cycle.
        idle(20);
        hls_finish = 1'b1;
        idle(1);
        hls_finish = 1'b0;
        chk("finish_clear", 32'(uart_start), 32'd0);

        send_byte(8'h53, 1'b1);
        chk("s2_start",    32'(uart_start), 32'd1);
        chk("s2_rise_cnt", 32'(n_rise),     32'd2);

        // A repeated start command while a run is pending is dropped.
        send_byte(8'h53, 1'b1);
        chk("s3_drop_cnt", 32'(n_drop),     32'd1);
        chk("s3_start",    32'(uart_start), 32'd1);
        chk("s3_rise_cnt", 32'(n_rise),     32'd2);

        // Abort command clears the pending request.
        send_byte(8'h41, 1'b1);
        chk("abort_start",     32'(uart_start), 32'd0);
        chk("abort_valid_cnt", 32'(n_valid),    32'd5);

        // A low stop bit gives a framing error and leaves rx_byte unchanged.
        send_byte(8'h53, 1'b0);
        chk("ferr_cnt",       32'(n_ferr),     32'd1);
        chk("ferr_valid_cnt", 32'(n_valid),    32'd5);
        chk("ferr_start",     32'(uart_start), 32'd0);
        chk("ferr_byte",      32'(rx_byte),    32'h41);

        // hls_finish while idle has no effect.
        hls_finish = 1'b1;
        idle(1);
        hls_finish = 1'b0;
        idle(2);
        chk("idle_finish_start", 32'(uart_start), 32'd0);
        chk("idle_finish_byte",  32'(rx_byte),    32'h41);

        // A short low glitch is rejected, and the next frame is received.
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(20);
        chk("glitch_valid_cnt", 32'(n_valid), 32'd5);
        chk("glitch_ferr_cnt",  32'(n_ferr),  32'd1);
        send_byte(8'h3C, 1'b1);
        chk("3c_valid_cnt", 32'(n_valid), 32'd6);
        chk("3c_byte",      32'(rx_byte), 32'h3C);
        chk("3c_ferr_cnt",  32'(n_ferr),  32'd1);

        // Set uart_start, then reset in the middle of a frame at bit 4.
        send_byte(8'h53, 1'b1);
        chk("s4_start", 32'(uart_start), 32'd1);
        partial = 8'h53;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        reset   = 1'b1;
        uart_rx = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("midrst_start",  32'(uart_start), 32'd0);
        chk("midrst_valid",  32'(rx_valid),   32'd0);
        chk("midrst_ferr",   32'(frame_err),  32'd0);
        chk("midrst_drop",   32'(cmd_drop),   32'd0);
        chk("midrst_byte",   32'(rx_byte),    32'h00);
        idle(30);
        chk("midrst_valid_cnt", 32'(n_valid), 32'd7);
        chk("midrst_ferr_cnt",  32'(n_ferr),  32'd1);

        // Reception resumes normally after the reset.
        send_byte(8'h53, 1'b1);
        chk("post_rst_start",    32'(uart_start), 32'd1);
        chk("post_rst_byte",     32'(rx_byte),    32'h53);
        chk("post_rst_rise_cnt", 32'(n_rise),     32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
